// File: rtl/ball_motion_pkg.sv
// Shared playfield geometry and ball-state encoding for the collision checker and ball_motion.
package ball_motion_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    MOVE  = 2'd1,
    LOST  = 2'd2,
    OVER  = 2'd3
  } ballState_e;

  localparam logic [7:0] SCREEN_W   = 8'd160;
  localparam logic [7:0] SCREEN_H   = 8'd120;
  localparam logic [7:0] PADDLE_Y   = 8'd110;
  localparam logic [7:0] PADDLE_LEN = 8'd16;

  localparam logic [7:0] X_MAX   = SCREEN_W - 8'd1;
  localparam logic [7:0] Y_MAX   = SCREEN_H - 8'd1;
  localparam logic [7:0] SERVE_Y = PADDLE_Y - 8'd1;

  // Ball x while resting on the paddle: paddle centre, pinned to the right edge.
  function automatic logic [7:0] serveX(input logic [7:0] paddleX);
    logic [8:0] centre;
    centre = {1'b0, paddleX} + {1'b0, PADDLE_LEN >> 1};
    return (centre > {1'b0, X_MAX}) ? X_MAX : centre[7:0];
  endfunction

endpackage

// File: rtl/ball_motion_axis_step.sv
// One-axis position step: moves pos by mag in direction dir, clamped to 0..limit.
module axis_step (
  input  logic [7:0] pos,
  input  logic [2:0] mag,
  input  logic       dir,
  input  logic [7:0] limit,
  output logic [7:0] nextPos
);

  logic [8:0] sum;
  logic [8:0] diff;

  assign sum  = {1'b0, pos} + {6'd0, mag};
  assign diff = {1'b0, pos} - {6'd0, mag};

  // NOTE: every path assigns nextPos, so this stays purely combinational.
  always_comb begin
    if (dir) begin
      nextPos = (sum > {1'b0, limit}) ? limit : sum[7:0];
    end else begin
      // A borrow out of the 9-bit difference means the ball ran past 0.
      nextPos = diff[8] ? 8'd0 : diff[7:0];
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball state stage: serve/launch, per-frame stepping with wall bounces, ball loss and lives.
module ball_motion
  import ball_motion_pkg::*;
#(
  parameter logic [2:0] INIT_VX     = 3'd1,
  parameter logic [2:0] INIT_VY     = 3'd2,
  parameter logic [1:0] LIVES       = 2'd3,
  parameter int         LOST_FRAMES = 30
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic       cX,
  input  logic       cY,
  input  logic [7:0] paddleX,
  output logic [7:0] ballX,
  output logic [7:0] ballY,
  output logic [2:0] vX,
  output logic [2:0] vY,
  output logic       dirX,
  output logic       dirY,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       ball_lost
);

  localparam int LOST_W = $clog2(LOST_FRAMES);

  ballState_e        state;
  ballState_e        stateNext;
  logic [LOST_W-1:0] lostCount;
  logic              lostDone;
  logic              ballMissed;
  logic              launchNow;
  logic              dirXNext;
  logic              dirYNext;
  logic [7:0]        stepX;
  logic [7:0]        stepY;

  assign launchNow  = frame_tick && launch;
  assign ballMissed = (ballY >= Y_MAX) && !cY;
  assign lostDone   = frame_tick && (lostCount == LOST_W'(LOST_FRAMES - 1));

  axis_step uStepX (
    .pos     (ballX),
    .mag     (vX),
    .dir     (dirXNext),
    .limit   (X_MAX),
    .nextPos (stepX)
  );

  axis_step uStepY (
    .pos     (ballY),
    .mag     (vY),
    .dir     (dirYNext),
    .limit   (Y_MAX),
    .nextPos (stepY)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SERVE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      SERVE: if (launchNow) stateNext = MOVE;
      MOVE:  if (frame_tick && ballMissed) stateNext = LOST;
      // lives was already decremented on entry, so zero here means no ball left.
      LOST:  if (lostDone) stateNext = (lives != 2'd0) ? SERVE : OVER;
      OVER:  stateNext = OVER;
      default: stateNext = SERVE;
    endcase
  end

  always_comb begin
    dirXNext  = dirX ^ cX;
    dirYNext  = dirY ^ cY;
    game_over = (state == OVER);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ballX     <= 8'd0;
      ballY     <= SERVE_Y;
      vX        <= 3'd0;
      vY        <= 3'd0;
      dirX      <= 1'b1;
      dirY      <= 1'b0;
      lives     <= LIVES;
      ball_lost <= 1'b0;
      lostCount <= '0;
    end else begin
      ball_lost <= 1'b0;
      unique case (state)
        SERVE: begin
          ballX <= serveX(paddleX);
          ballY <= SERVE_Y;
          vX    <= 3'd0;
          vY    <= 3'd0;
          if (launchNow) begin
            vX   <= INIT_VX;
            vY   <= INIT_VY;
            dirX <= 1'b1;
            dirY <= 1'b0;
          end
        end
        MOVE: begin
          if (frame_tick) begin
            if (ballMissed) begin
              vX        <= 3'd0;
              vY        <= 3'd0;
              lives     <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
              ball_lost <= 1'b1;
            end else begin
              dirX  <= dirXNext;
              dirY  <= dirYNext;
              ballX <= stepX;
              ballY <= stepY;
            end
          end
        end
        LOST: begin
          if (frame_tick) begin
            lostCount <= lostDone ? '0 : lostCount + LOST_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: integer reference model, per-cycle compare, directed and random stimulus.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_tick;
  logic       launch;
  logic       cX;
  logic       cY;
  logic [7:0] paddleX;
  logic [7:0] ballX;
  logic [7:0] ballY;
  logic [2:0] vX;
  logic [2:0] vY;
  logic       dirX;
  logic       dirY;
  logic [1:0] lives;
  logic       game_over;
  logic       ball_lost;

  int vectors = 0;
  int miscompares = 0;

  ball_motion dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .launch     (launch),
    .cX         (cX),
    .cY         (cY),
    .paddleX    (paddleX),
    .ballX      (ballX),
    .ballY      (ballY),
    .vX         (vX),
    .vY         (vY),
    .dirX       (dirX),
    .dirY       (dirY),
    .lives      (lives),
    .game_over  (game_over),
    .ball_lost  (ball_lost)
  );

  always #5 clk = ~clk;

  // Reference model: game rules in plain integers.
  localparam int M_SERVE = 0, M_MOVE = 1, M_LOST = 2, M_OVER = 3;
  int mState, mX, mY, mVx, mVy, mDx, mDy, mLives, mTicks, mPulse;

  function automatic int clampInt(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic modelReset();
    mState = M_SERVE; mX = 0; mY = 109; mVx = 0; mVy = 0;
    mDx = 1; mDy = 0; mLives = 3; mTicks = 0; mPulse = 0;
  endtask

  task automatic modelEdge();
    mPulse = 0;
    case (mState)
      M_SERVE: begin
        mX = clampInt(int'(paddleX) + 8, 159);
        mY = 109; mVx = 0; mVy = 0;
        if (frame_tick && launch) begin
          mVx = 1; mVy = 2; mDx = 1; mDy = 0; mState = M_MOVE;
        end
      end
      M_MOVE: if (frame_tick) begin
        if (mY >= 119 && !cY) begin
          mState = M_LOST; mVx = 0; mVy = 0; mPulse = 1;
          mLives = (mLives > 0) ? mLives - 1 : 0;
        end else begin
          mDx = mDx ^ int'(cX);
          mDy = mDy ^ int'(cY);
          mX = clampInt(mDx ? mX + mVx : mX - mVx, 159);
          mY = clampInt(mDy ? mY + mVy : mY - mVy, 119);
        end
      end
      M_LOST: if (frame_tick) begin
        mTicks++;
        if (mTicks == 30) begin
          mTicks = 0;
          mState = (mLives > 0) ? M_SERVE : M_OVER;
        end
      end
      default: ;
    endcase
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) modelReset();
      else modelEdge();
    end
  end

  // Whole-output compare on every falling edge.
  initial begin
    logic [27:0] act, exp;
    forever begin
      @(negedge clk);
      act = {ballX, ballY, vX, vY, dirX, dirY, lives, game_over, ball_lost};
      exp = {8'(mX), 8'(mY), 3'(mVx), 3'(mVy), 1'(mDx), 1'(mDy), 2'(mLives),
             1'(mState == M_OVER), 1'(mPulse)};
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL model_compare t=%0t: got %h expected %h", $time, act, exp);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs are set just after an edge and held across the next rising edge.
  task automatic drive(input bit t, input bit la, input bit cx, input bit cy);
    frame_tick = t; launch = la; cX = cx; cY = cy;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    frame_tick = 0; launch = 0; cX = 0; cY = 0;
    #2 resetn = 0;
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;
  endtask

  // From SERVE with the ball on the paddle: launch, bounce down once, fall off the bottom.
  task automatic loseBall();
    drive(1, 1, 0, 0);
    drive(1, 0, 0, 1);
    repeat (4) drive(1, 0, 0, 0);
    drive(1, 0, 0, 0);
  endtask

  initial begin
    resetn = 0; frame_tick = 0; launch = 0; cX = 0; cY = 0; paddleX = 8'd40;
    #12;
    check("reset_ballX", ballX, 0);
    check("reset_ballY", ballY, 109);
    check("reset_vX", vX, 0);
    check("reset_dirX", dirX, 1);
    check("reset_lives", lives, 3);
    check("reset_game_over", game_over, 0);
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;

    drive(0, 0, 0, 0);
    check("serve_ballX", ballX, 48);
    check("serve_ballY", ballY, 109);
    paddleX = 8'd200;
    drive(0, 0, 0, 0);
    check("serve_saturate", ballX, 159);
    paddleX = 8'd40;
    drive(0, 1, 0, 0);
    check("launch_needs_tick_vX", vX, 0);
    drive(1, 1, 0, 0);
    check("launch_vX", vX, 1);
    check("launch_vY", vY, 2);
    drive(0, 0, 1, 1);
    check("no_tick_ballX", ballX, 48);
    check("no_tick_dirX", dirX, 1);
    drive(1, 0, 0, 0);
    check("first_step_ballX", ballX, 49);
    check("first_step_ballY", ballY, 107);
    check("first_step_dirY", dirY, 0);

    repeat (53) drive(1, 0, 0, 0);
    check("near_top_ballY", ballY, 1);
    drive(1, 0, 0, 0);
    check("underflow_clamp", ballY, 0);
    drive(1, 0, 0, 1);
    check("top_bounce_dirY", dirY, 1);
    check("top_bounce_ballY", ballY, 2);

    repeat (55) drive(1, 0, 0, 0);
    check("right_wall_ballX", ballX, 159);
    drive(0, 0, 1, 0);
    check("cX_without_tick", dirX, 1);
    drive(1, 0, 1, 0);
    check("x_bounce_dirX", dirX, 0);
    check("x_bounce_ballX", ballX, 158);
    repeat (3) drive(1, 0, 0, 0);
    check("bottom_clamp", ballY, 119);
    drive(1, 0, 0, 1);
    check("bottom_bounce_dirY", dirY, 0);
    check("bottom_bounce_no_loss", ball_lost, 0);
    check("bottom_bounce_ballY", ballY, 117);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 0);
    check("lost_pulse", ball_lost, 1);
    check("lost_lives", lives, 2);
    check("lost_hold_ballY", ballY, 119);
    drive(1, 1, 0, 0);
    check("lost_pulse_one_cycle", ball_lost, 0);
    repeat (28) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("lost_29_hold", ballY, 119);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("reserve_ballY", ballY, 109);
    check("reserve_ballX", ballX, 48);

    loseBall();
    check("second_loss_lives", lives, 1);
    repeat (30) drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    loseBall();
    check("third_loss_lives", lives, 0);
    repeat (29) drive(1, 0, 0, 0);
    check("over_not_yet", game_over, 0);
    drive(1, 0, 0, 0);
    check("game_over", game_over, 1);
    repeat (3) drive(1, 1, 0, 0);
    check("over_launch_ignored", vX, 0);
    check("over_still", game_over, 1);

    doReset();
    drive(0, 0, 0, 0);
    loseBall();
    check("pre_async_lives", lives, 2);
    repeat (15) drive(1, 0, 0, 0);
    frame_tick = 0;
    #2 resetn = 0;
    #1;
    check("async_ballX", ballX, 0);
    check("async_ballY", ballY, 109);
    check("async_lives", lives, 3);
    check("async_vY", vY, 0);
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 4000; i++) begin
      bit t, la, cx, cy;
      if (i % 1000 == 999) doReset();
      t  = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) paddleX = 8'($urandom_range(0, 255));
      cx = (dirX && int'(ballX) + int'(vX) > 159) || (!dirX && ballX < 8'(vX))
           || ($urandom_range(0, 31) == 0);
      cy = (!dirY && ballY < 8'(vY)) || (dirY && ballY >= 8'd115 && $urandom_range(0, 3) != 0)
           || ($urandom_range(0, 31) == 0);
      drive(t, la, cx, cy);
    end

    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
